// File: rtl/key_debounce_if.sv
// Push-button bus: raw active-low key in, debounced level and event pulses out.
interface key_debounce_if;
  logic key_in;
  logic key_out;
  logic key_press;
  logic key_release;
  logic key_long;

  modport master (
    output key_in,
    input  key_out,
    input  key_press,
    input  key_release,
    input  key_long
  );

  modport slave (
    input  key_in,
    output key_out,
    output key_press,
    output key_release,
    output key_long
  );
endinterface

// File: rtl/key_debounce.sv
// Synchronises and debounces an active-low push button, producing a clean level
// plus one-cycle press, release and long-press pulses, all registered.
module key_debounce #(
  parameter logic [19:0] CNT_FILT = 20'd999_999,
  parameter logic [25:0] CNT_LONG = 26'd49_999_999
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  key_debounce_if.slave key_bus
);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_FILT,
    DOWN,
    RELEASE_FILT
  } state_e;

  state_e      state_q, state_d;
  logic        sync1_q, sync2_q;
  logic [19:0] cnt_q, cnt_d;
  logic [25:0] hold_q, hold_d;
  logic        key_out_q, key_out_d;
  logic        press_q, press_d;
  logic        release_q, release_d;
  logic        long_q, long_d;

  // Sync flops idle high so a button held through reset still needs a full filter.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= key_bus.key_in;
      sync2_q <= sync1_q;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= 20'd0;
      hold_q    <= 26'd0;
      key_out_q <= 1'b1;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hold_q    <= hold_d;
      key_out_q <= key_out_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hold_d    = hold_q;
    key_out_d = key_out_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (!sync2_q) begin
          state_d = PRESS_FILT;
          cnt_d   = 20'd0;
        end
      end
      PRESS_FILT: begin
        if (sync2_q) begin
          state_d = IDLE;
          cnt_d   = 20'd0;
        end else if (cnt_q == CNT_FILT) begin
          state_d   = DOWN;
          cnt_d     = 20'd0;
          key_out_d = 1'b0;
          press_d   = 1'b1;
          hold_d    = 26'd0;
        end else begin
          cnt_d = cnt_q + 20'd1;
        end
      end
      DOWN: begin
        if (sync2_q) begin
          state_d = RELEASE_FILT;
          cnt_d   = 20'd0;
        end
      end
      RELEASE_FILT: begin
        if (!sync2_q) begin
          state_d = DOWN;
          cnt_d   = 20'd0;
        end else if (cnt_q == CNT_FILT) begin
          state_d   = IDLE;
          cnt_d     = 20'd0;
          key_out_d = 1'b1;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 20'd1;
        end
      end
      default: begin
        state_d   = IDLE;
        cnt_d     = 20'd0;
        key_out_d = 1'b1;
      end
    endcase

    // Hold time keeps accumulating through release bounces and saturates at the threshold.
    if (((state_q == DOWN) || (state_q == RELEASE_FILT)) && (hold_q < CNT_LONG)) begin
      hold_d = hold_q + 26'd1;
      long_d = ((hold_q + 26'd1) == CNT_LONG);
    end
  end

  assign key_bus.key_out     = key_out_q;
  assign key_bus.key_press   = press_q;
  assign key_bus.key_release = release_q;
  assign key_bus.key_long    = long_q;

endmodule

// File: tb/tb_key_debounce.sv
// Scoreboard bench for key_debounce: expected pulses are queued with their cycle
// stamps as stimulus is driven, and a monitor pops and compares every pulse seen.
module tb_key_debounce;

  typedef struct {
    int cyc;
    int kind;
  } evt_t;

  logic sys_clk;
  logic sys_rst_n;
  int   cyc;
  int   compared;
  int   mismatched;
  evt_t expQ[$];

  key_debounce_if kbus();

  key_debounce #(
    .CNT_FILT(20'd9),
    .CNT_LONG(26'd49)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .key_bus  (kbus)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc <= cyc + 1;

  function automatic string kindName(input int k);
    case (k)
      0:       return "press";
      1:       return "release";
      default: return "long";
    endcase
  endfunction

  // Every pulse the DUT emits must match the oldest outstanding expectation.
  always @(negedge sys_clk) begin
    logic seen;
    evt_t e;
    if (sys_rst_n) begin
      for (int k = 0; k < 3; k++) begin
        seen = (k == 0) ? kbus.key_press : (k == 1) ? kbus.key_release : kbus.key_long;
        if (seen === 1'b1) begin
          compared++;
          if (expQ.size() == 0) begin
            mismatched++;
            $display("[TB] FAIL unexpected_%s: pulse at cycle %0d, expected no pulse", kindName(k), cyc);
          end else begin
            e = expQ.pop_front();
            if (e.kind !== k || e.cyc !== cyc) begin
              mismatched++;
              $display("[TB] FAIL pulse_order: got %s at cycle %0d, expected %s at cycle %0d",
                       kindName(k), cyc, kindName(e.kind), e.cyc);
            end
          end
        end
      end
    end
  end

  // Entered and left 1 time unit after a rising edge; the level is sampled on n edges.
  task automatic applyStimulus(input logic lvl, input int n);
    kbus.key_in = lvl;
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic expectEvent(input int when, input int kind);
    evt_t e;
    e.cyc  = when;
    e.kind = kind;
    expQ.push_back(e);
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0;
    kbus.key_in = 1'b1;
    repeat (3) @(posedge sys_clk);
    #1;
    compared++;
    if (kbus.key_out !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL reset_key_out: got %b, expected 1", kbus.key_out);
    end
    compared++;
    if ({kbus.key_press, kbus.key_release, kbus.key_long} !== 3'b000) begin
      mismatched++;
      $display("[TB] FAIL reset_pulses: got %b, expected 000",
               {kbus.key_press, kbus.key_release, kbus.key_long});
    end
    sys_rst_n = 1'b1;
    applyStimulus(1'b1, 5);
    compared++;
    if (kbus.key_out !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL reset_idle_out: got %b, expected 1", kbus.key_out);
    end
  endtask

  task automatic test_clean_press();
    int s;
    int r;
    s = cyc + 1;
    expectEvent(s + 12, 0);
    applyStimulus(1'b0, 12);
    compared++;
    if (kbus.key_out !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL clean_before_press: key_out=%b, expected 1", kbus.key_out);
    end
    applyStimulus(1'b0, 1);
    compared++;
    if (kbus.key_out !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL clean_after_press: key_out=%b, expected 0", kbus.key_out);
    end
    applyStimulus(1'b0, 17);
    r = cyc + 1;
    expectEvent(r + 12, 1);
    applyStimulus(1'b1, 12);
    compared++;
    if (kbus.key_out !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL clean_before_release: key_out=%b, expected 0", kbus.key_out);
    end
    applyStimulus(1'b1, 1);
    compared++;
    if (kbus.key_out !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL clean_after_release: key_out=%b, expected 1", kbus.key_out);
    end
    applyStimulus(1'b1, 10);
  endtask

  task automatic test_press_bounce();
    int s;
    int r;
    applyStimulus(1'b0, 3);
    applyStimulus(1'b1, 2);
    applyStimulus(1'b0, 4);
    applyStimulus(1'b1, 1);
    s = cyc + 1;
    expectEvent(s + 12, 0);
    applyStimulus(1'b0, 11);
    compared++;
    if (kbus.key_out !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL bounce_early_out: key_out=%b, expected 1", kbus.key_out);
    end
    applyStimulus(1'b0, 9);
    r = cyc + 1;
    expectEvent(r + 12, 1);
    applyStimulus(1'b1, 20);
  endtask

  task automatic test_long_hold();
    int s;
    int r;
    s = cyc + 1;
    expectEvent(s + 12, 0);
    expectEvent(s + 12 + 49, 2);
    applyStimulus(1'b0, 80);
    compared++;
    if (kbus.key_out !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL long_held_out: key_out=%b, expected 0", kbus.key_out);
    end
    r = cyc + 1;
    expectEvent(r + 12, 1);
    applyStimulus(1'b1, 20);
  endtask

  task automatic test_release_bounce();
    int s;
    int r;
    s = cyc + 1;
    expectEvent(s + 12, 0);
    // Long lands one cycle before the release, only if the bounce left hold time intact.
    expectEvent(s + 61, 2);
    applyStimulus(1'b0, 42);
    applyStimulus(1'b1, 5);
    compared++;
    if (kbus.key_out !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL relbounce_glitch_high: key_out=%b, expected 0", kbus.key_out);
    end
    applyStimulus(1'b0, 3);
    compared++;
    if (kbus.key_out !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL relbounce_glitch_low: key_out=%b, expected 0", kbus.key_out);
    end
    r = cyc + 1;
    expectEvent(r + 12, 1);
    applyStimulus(1'b1, 15);
    compared++;
    if (kbus.key_out !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL relbounce_final_out: key_out=%b, expected 1", kbus.key_out);
    end
    applyStimulus(1'b1, 10);
  endtask

  task automatic test_reset_mid_down();
    int s;
    int r;
    s = cyc + 1;
    expectEvent(s + 12, 0);
    applyStimulus(1'b0, 20);
    sys_rst_n = 1'b0;
    #1;
    compared++;
    if (kbus.key_out !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL midreset_key_out: got %b, expected 1", kbus.key_out);
    end
    compared++;
    if ({kbus.key_press, kbus.key_release, kbus.key_long} !== 3'b000) begin
      mismatched++;
      $display("[TB] FAIL midreset_pulses: got %b, expected 000",
               {kbus.key_press, kbus.key_release, kbus.key_long});
    end
    repeat (2) @(posedge sys_clk);
    #1;
    s = cyc + 1;
    expectEvent(s + 12, 0);
    sys_rst_n = 1'b1;
    applyStimulus(1'b0, 12);
    compared++;
    if (kbus.key_out !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL midreset_refilter_out: key_out=%b, expected 1", kbus.key_out);
    end
    applyStimulus(1'b0, 5);
    r = cyc + 1;
    expectEvent(r + 12, 1);
    applyStimulus(1'b1, 20);
  endtask

  task automatic test_glitch_reject();
    applyStimulus(1'b0, 1);
    applyStimulus(1'b1, 20);
    compared++;
    if (kbus.key_out !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL glitch1_out: key_out=%b, expected 1", kbus.key_out);
    end
    applyStimulus(1'b0, 9);
    applyStimulus(1'b1, 20);
    compared++;
    if (kbus.key_out !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL glitch9_out: key_out=%b, expected 1", kbus.key_out);
    end
  endtask

  task automatic test_drained(input string tag);
    compared++;
    if (expQ.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL %s_missing: %0d expected pulses never seen, expected 0 outstanding",
               tag, expQ.size());
      expQ.delete();
    end
  endtask

  initial begin
    cyc        = 0;
    compared   = 0;
    mismatched = 0;
    test_reset();
    test_clean_press();
    test_drained("clean");
    test_press_bounce();
    test_drained("press_bounce");
    test_long_hold();
    test_drained("long_hold");
    test_release_bounce();
    test_drained("release_bounce");
    test_reset_mid_down();
    test_drained("reset_mid_down");
    test_glitch_reject();
    test_drained("glitch");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
